// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 scan-code decoder: strips E0/F0 prefixes, queues key events in a
// show-ahead FIFO and tracks the held state of the eight game-control keys.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] keycode,
    input  logic        oflag,
    output logic        ev_valid,
    output logic [7:0]  ev_code,
    output logic        ev_ext,
    output logic        ev_break,
    input  logic        ev_ready,
    output logic [7:0]  keys,
    output logic        overflow
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state, next_state;
    logic [TW-1:0] to_cnt;
    logic [7:0]    b;
    logic          emit, emit_ext, emit_brk;
    logic          key_hit;
    logic [2:0]    key_idx;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [9:0]    last_q;
    logic          full, empty, push, pop;
    logic          unused_hi;

    assign b         = keycode[7:0];
    assign unused_hi = ^keycode[15:8];

    function automatic logic is_ignored(input logic [7:0] v);
        case (v)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default: is_ignored = 1'b0;
        endcase
    endfunction

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_brk   = 1'b0;
        if (oflag) begin
            case (state)
                IDLE: begin
                    if (b == 8'hE0)           next_state = EXT;
                    else if (b == 8'hF0)      next_state = BRK;
                    else if (!is_ignored(b))  emit = 1'b1;
                end
                EXT: begin
                    if (b == 8'hF0)           next_state = EXT_BRK;
                    else if (b != 8'hE0) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        next_state = IDLE;
                    end
                end
                BRK: begin
                    if (b == 8'hE0)           next_state = EXT_BRK;
                    else if (b != 8'hF0) begin
                        emit       = 1'b1;
                        emit_brk   = 1'b1;
                        next_state = IDLE;
                    end
                end
                default: begin
                    if (b != 8'hE0 && b != 8'hF0) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        emit_brk   = 1'b1;
                        next_state = IDLE;
                    end
                end
            endcase
        end else if (state != IDLE && to_cnt == TO_LAST) begin
            // A stalled prefix is abandoned silently; a late byte then decodes from IDLE.
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state <= next_state;
            if (oflag || next_state == IDLE)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        key_hit = 1'b1;
        key_idx = 3'd0;
        case ({emit_ext, b})
            9'h01D: key_idx = 3'd0;
            9'h01C: key_idx = 3'd1;
            9'h01B: key_idx = 3'd2;
            9'h023: key_idx = 3'd3;
            9'h175: key_idx = 3'd4;
            9'h16B: key_idx = 3'd5;
            9'h172: key_idx = 3'd6;
            9'h174: key_idx = 3'd7;
            default: key_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            keys <= '0;
        else if (emit && key_hit)
            keys[key_idx] <= ~emit_brk;
    end

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = ev_valid & ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push  = emit & (~full | pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {b, emit_ext, emit_brk};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (emit && !push)
                overflow <= 1'b1;
        end
    end

    // When empty the outputs keep showing the most recently consumed event.
    assign ev_valid = ~empty;
    assign {ev_code, ev_ext, ev_break} = empty ? last_q : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table-driven decode vectors plus
// hand-written timeout, overflow, full push/pop and mid-sequence reset cases.
module tb_ps2_key_decoder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keycode = '0;
    logic        oflag = 1'b0;
    logic        ev_valid;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_break;
    logic        ev_ready = 1'b0;
    logic [7:0]  keys;
    logic        overflow;

    int total = 0;
    int bad = 0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .keycode(keycode), .oflag(oflag),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_break(ev_break), .ev_ready(ev_ready), .keys(keys),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       ev;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] keys;
    } vec_t;

    vec_t vecs [24];

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] byte_in);
        keycode = {8'h5A, byte_in};
        oflag   = 1'b1;
        @(posedge clk);
        #1;
        oflag   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] code, input logic ext,
                               input logic brk, input logic [7:0] k);
        check1({tag, " valid"}, ev_valid, 1'b1);
        check8({tag, " code"}, ev_code, code);
        check1({tag, " ext"}, ev_ext, ext);
        check1({tag, " brk"}, ev_break, brk);
        check8({tag, " keys"}, keys, k);
    endtask

    task automatic doReset();
        oflag    = 1'b0;
        ev_ready = 1'b0;
        rst_n    = 1'b0;
        idleCycles(2);
        rst_n    = 1'b1;
    endtask

    task automatic drainExpect(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check1($sformatf("%s drain%0d valid", tag, i), ev_valid, 1'b1);
            check8($sformatf("%s drain%0d code", tag, i), ev_code, e[i]);
            idleCycles(1);
        end
        check1({tag, " drained empty"}, ev_valid, 1'b0);
        check8({tag, " drained hold"}, ev_code, e3);
        ev_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'h1D, 1'b1, 8'h1D, 1'b0, 1'b0, 8'h01};
        vecs[1]  = '{8'hE0, 1'b0, 8'h1D, 1'b0, 1'b0, 8'h01};
        vecs[2]  = '{8'h74, 1'b1, 8'h74, 1'b1, 1'b0, 8'h81};
        vecs[3]  = '{8'hE0, 1'b0, 8'h74, 1'b0, 1'b0, 8'h81};
        vecs[4]  = '{8'hF0, 1'b0, 8'h74, 1'b0, 1'b0, 8'h81};
        vecs[5]  = '{8'h74, 1'b1, 8'h74, 1'b1, 1'b1, 8'h01};
        vecs[6]  = '{8'hE0, 1'b0, 8'h74, 1'b0, 1'b0, 8'h01};
        vecs[7]  = '{8'h1D, 1'b1, 8'h1D, 1'b1, 1'b0, 8'h01};
        vecs[8]  = '{8'hF0, 1'b0, 8'h1D, 1'b0, 1'b0, 8'h01};
        vecs[9]  = '{8'h1D, 1'b1, 8'h1D, 1'b0, 1'b1, 8'h00};
        vecs[10] = '{8'hFA, 1'b0, 8'h1D, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{8'hE1, 1'b1, 8'hE1, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{8'hF0, 1'b0, 8'hE1, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{8'hE0, 1'b0, 8'hE1, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{8'h6B, 1'b1, 8'h6B, 1'b1, 1'b1, 8'h00};
        vecs[15] = '{8'hE0, 1'b0, 8'h6B, 1'b0, 1'b0, 8'h00};
        vecs[16] = '{8'h6B, 1'b1, 8'h6B, 1'b1, 1'b0, 8'h20};
        vecs[17] = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 8'h22};
        vecs[18] = '{8'hE0, 1'b0, 8'h1C, 1'b0, 1'b0, 8'h22};
        vecs[19] = '{8'hE0, 1'b0, 8'h1C, 1'b0, 1'b0, 8'h22};
        vecs[20] = '{8'h72, 1'b1, 8'h72, 1'b1, 1'b0, 8'h62};
        vecs[21] = '{8'hF0, 1'b0, 8'h72, 1'b0, 1'b0, 8'h62};
        vecs[22] = '{8'hF0, 1'b0, 8'h72, 1'b0, 1'b0, 8'h62};
        vecs[23] = '{8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 8'h60};

        // Reset values
        doReset();
        check1("rst valid", ev_valid, 1'b0);
        check8("rst code", ev_code, 8'h00);
        check1("rst ext", ev_ext, 1'b0);
        check1("rst brk", ev_break, 1'b0);
        check8("rst keys", keys, 8'h00);
        check1("rst overflow", overflow, 1'b0);

        // Decode table, consumer always ready
        ev_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].b);
            check1($sformatf("row%0d valid", i), ev_valid, vecs[i].ev);
            check8($sformatf("row%0d code", i), ev_code, vecs[i].code);
            check8($sformatf("row%0d keys", i), keys, vecs[i].keys);
            if (vecs[i].ev) begin
                check1($sformatf("row%0d ext", i), ev_ext, vecs[i].ext);
                check1($sformatf("row%0d brk", i), ev_break, vecs[i].brk);
            end
        end

        // Timeout boundary: last-cycle byte still decodes as break, one later does not
        doReset();
        ev_ready = 1'b1;
        applyStimulus(8'h1B);
        checkOutput("to make S", 8'h1B, 1'b0, 1'b0, 8'h04);
        applyStimulus(8'hF0);
        idleCycles(TO - 1);
        applyStimulus(8'h1B);
        checkOutput("to last-cycle break", 8'h1B, 1'b0, 1'b1, 8'h00);
        applyStimulus(8'hF0);
        idleCycles(TO);
        applyStimulus(8'h1C);
        checkOutput("to expired make", 8'h1C, 1'b0, 1'b0, 8'h02);

        // Overflow with consumer stalled
        doReset();
        applyStimulus(8'h15);
        applyStimulus(8'h1D);
        applyStimulus(8'h24);
        applyStimulus(8'h2D);
        check1("ovf at full", overflow, 1'b0);
        applyStimulus(8'h2C);
        check1("ovf set", overflow, 1'b1);
        checkOutput("ovf head", 8'h15, 1'b0, 1'b0, 8'h01);
        drainExpect("ovf", 8'h15, 8'h1D, 8'h24, 8'h2D);
        check1("ovf sticky", overflow, 1'b1);

        // Full FIFO with push and pop on the same cycle
        doReset();
        applyStimulus(8'h16);
        applyStimulus(8'h1E);
        applyStimulus(8'h26);
        applyStimulus(8'h25);
        ev_ready = 1'b1;
        applyStimulus(8'h2E);
        ev_ready = 1'b0;
        check1("pp overflow", overflow, 1'b0);
        drainExpect("pp", 8'h1E, 8'h26, 8'h25, 8'h2E);

        // Discarded bytes and reset mid-prefix
        doReset();
        applyStimulus(8'h1D);
        applyStimulus(8'hAA);
        applyStimulus(8'hFA);
        checkOutput("mr held head", 8'h1D, 1'b0, 1'b0, 8'h01);
        applyStimulus(8'hE0);
        rst_n = 1'b0;
        #2;
        check1("mr valid in reset", ev_valid, 1'b0);
        check8("mr keys in reset", keys, 8'h00);
        check8("mr code in reset", ev_code, 8'h00);
        rst_n = 1'b1;
        #1;
        applyStimulus(8'h75);
        checkOutput("mr after reset", 8'h75, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
